rr_grant_encoder8: RTL and testbench



---
 rtl/rr_grant_encoder8.sv | 103 ++++++++++
 tb/tb_rr_grant_encoder8.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_encoder8.sv
// rtl/rr_grant_encoder8.sv - 8-way round-robin arbiter with registered 3-bit grant index
// Optional hold-time revocation is compiled in with `define RR_TIMEOUT_EN.
module rr_grant_encoder8 #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
`ifdef RR_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] Req_in,
    input  logic             Release_in,
    output logic [IDX_W-1:0] Grant_idx,
    output logic             Grant_valid,
    output logic             Timeout_flag
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic             owner_done;
    logic             timeout_hit;
    logic             exit_grant;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        winner = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (Req_in[ptr + IDX_W'(i)]) begin
                winner = ptr + IDX_W'(i);
            end
        end
    end

    assign owner_done = Release_in | ~Req_in[Grant_idx];

`ifdef RR_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign timeout_hit = (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign timeout_hit  = 1'b0;
    assign Timeout_flag = 1'b0;
`endif

    assign exit_grant = owner_done | timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            Grant_idx   <= '0;
            Grant_valid <= 1'b0;
`ifdef RR_TIMEOUT_EN
            hold_cnt     <= 8'd0;
            Timeout_flag <= 1'b0;
`endif
        end else begin
`ifdef RR_TIMEOUT_EN
            Timeout_flag <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|Req_in) begin
                        Grant_idx   <= winner;
                        Grant_valid <= 1'b1;
                        state       <= GRANT;
`ifdef RR_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (exit_grant) begin
                        Grant_valid <= 1'b0;
                        ptr         <= Grant_idx + IDX_W'(1);
                        state       <= IDLE;
`ifdef RR_TIMEOUT_EN
                        // A genuine release or drop in the timeout cycle is not a revocation.
                        Timeout_flag <= ~owner_done;
`endif
                    end else begin
`ifdef RR_TIMEOUT_EN
                        hold_cnt <= hold_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    Grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_encoder8.sv
// tb/tb_rr_grant_encoder8.sv - directed self-checking bench for rr_grant_encoder8
module tb_rr_grant_encoder8;

    logic       clk;
    logic       rst;
    logic [7:0] Req_in;
    logic       Release_in;
    logic [2:0] Grant_idx;
    logic       Grant_valid;
    logic       Timeout_flag;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef RR_TIMEOUT_EN
    rr_grant_encoder8 #(.MAX_HOLD(4)) dut (
`else
    rr_grant_encoder8 dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .Req_in      (Req_in),
        .Release_in  (Release_in),
        .Grant_idx   (Grant_idx),
        .Grant_valid (Grant_valid),
        .Timeout_flag(Timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        Req_in     = 8'h00;
        Release_in = 1'b0;
        tick();
        tick();
        check("reset_idx", Grant_idx, 8'd0);
        check("reset_valid", Grant_valid, 8'd0);
        check("reset_tflag", Timeout_flag, 8'd0);
        rst = 1'b0;

        // Asynchronous reset in the middle of a grant to requester 5
        Req_in = 8'h20;
        tick();
        check("pre_rst_idx", Grant_idx, 8'd5);
        check("pre_rst_valid", Grant_valid, 8'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_idx", Grant_idx, 8'd0);
        check("async_rst_valid", Grant_valid, 8'd0);
        rst = 1'b0;
        tick();
        check("post_rst_idx", Grant_idx, 8'd5);
        check("post_rst_valid", Grant_valid, 8'd1);
        Release_in = 1'b1;
        tick();
        check("post_rst_rel", Grant_valid, 8'd0);
        Release_in = 1'b0;

        // ptr = 6: request 0 and 1 wraps to 0 first, then 1
        Req_in = 8'h03;
        tick();
        check("wrap_idx0", Grant_idx, 8'd0);
        check("wrap_valid0", Grant_valid, 8'd1);
        Release_in = 1'b1;
        tick();
        check("wrap_gap0", Grant_valid, 8'd0);
        Release_in = 1'b0;
        tick();
        check("wrap_idx1", Grant_idx, 8'd1);
        check("wrap_valid1", Grant_valid, 8'd1);
        Release_in = 1'b1;
        tick();
        check("wrap_gap1", Grant_valid, 8'd0);
        Release_in = 1'b0;
        Req_in = 8'h40;
        tick();
        check("grant6_idx", Grant_idx, 8'd6);
        Release_in = 1'b1;
        tick();
        Release_in = 1'b0;
        Req_in = 8'h41;
        tick();
        check("ptr7_idx", Grant_idx, 8'd0);
        check("ptr7_valid", Grant_valid, 8'd1);
        Req_in = 8'h00;
        tick();
        check("ptr7_drop", Grant_valid, 8'd0);

        // Release in IDLE is ignored; release in the first grant cycle ends it
        Release_in = 1'b1;
        tick();
        check("idle_rel_valid", Grant_valid, 8'd0);
        Req_in = 8'h02;
        tick();
        check("min_grant_idx", Grant_idx, 8'd1);
        check("min_grant_valid", Grant_valid, 8'd1);
        tick();
        check("min_grant_end", Grant_valid, 8'd0);
        Release_in = 1'b0;
        Req_in = 8'h00;
        tick();

        // Single request from ptr=2: requester 3, then ptr=4 picks 0 over 3
        Req_in = 8'h08;
        tick();
        check("single_idx", Grant_idx, 8'd3);
        check("single_valid", Grant_valid, 8'd1);
        Release_in = 1'b1;
        tick();
        check("single_rel", Grant_valid, 8'd0);
        Release_in = 1'b0;
        Req_in = 8'h09;
        tick();
        check("ptr4_idx", Grant_idx, 8'd0);
        Req_in = 8'h00;
        tick();
        check("ptr4_drop", Grant_valid, 8'd0);

        // Fresh reset, then full round-robin with everyone requesting
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        Req_in = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rr_idx_%0d", i), Grant_idx, 8'(i % 8));
            check($sformatf("rr_valid_%0d", i), Grant_valid, 8'd1);
            Release_in = 1'b1;
            tick();
            check($sformatf("rr_gap_%0d", i), Grant_valid, 8'd0);
            Release_in = 1'b0;
        end

        // ptr = 1: grant 2, toggle bit 4 during grant, then drop bit 2
        Req_in = 8'h04;
        tick();
        check("drop_idx", Grant_idx, 8'd2);
        Req_in = 8'h14;
        tick();
        check("toggle_idx_a", Grant_idx, 8'd2);
        check("toggle_valid_a", Grant_valid, 8'd1);
        Req_in = 8'h04;
        tick();
        check("toggle_idx_b", Grant_idx, 8'd2);
        Req_in = 8'h10;
        tick();
        check("drop_valid", Grant_valid, 8'd0);
        check("drop_idx_hold", Grant_idx, 8'd2);
        tick();
        check("after_drop_idx", Grant_idx, 8'd4);
        check("after_drop_valid", Grant_valid, 8'd1);
        Req_in = 8'h00;
        tick();
        check("idle_idx_hold", Grant_idx, 8'd4);
        check("idle_valid", Grant_valid, 8'd0);

`ifdef RR_TIMEOUT_EN
        // MAX_HOLD = 4: four valid cycles, revoke with a one-cycle flag
        Req_in = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to_valid_%0d", i), Grant_valid, 8'd1);
            check($sformatf("to_flag_%0d", i), Timeout_flag, 8'd0);
        end
        tick();
        check("to_revoke_valid", Grant_valid, 8'd0);
        check("to_revoke_flag", Timeout_flag, 8'd1);
        tick();
        check("to_regrant_idx", Grant_idx, 8'd0);
        check("to_regrant_valid", Grant_valid, 8'd1);
        check("to_flag_cleared", Timeout_flag, 8'd0);
        tick();
        tick();
        tick();
        Release_in = 1'b1;
        tick();
        check("to_rel_valid", Grant_valid, 8'd0);
        check("to_rel_flag", Timeout_flag, 8'd0);
        Release_in = 1'b0;
        Req_in = 8'h00;
`else
        // Without the timeout a held request keeps its grant indefinitely
        Req_in = 8'h01;
        tick();
        check("hold_idx", Grant_idx, 8'd0);
        for (int i = 0; i < 20; i++) tick();
        check("hold_valid", Grant_valid, 8'd1);
        check("hold_tflag", Timeout_flag, 8'd0);
        Req_in = 8'h00;
        tick();
        check("hold_drop", Grant_valid, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
